// File: rtl/dna_gate_pkg.sv
// Shared types and constants for the DNA-gated AXI-Stream path.
package dna_gate_pkg;

  // Gate state; the same encoding is presented on the status port.
  typedef enum logic [1:0] {
    GS_WAIT = 2'b00,
    GS_PASS = 2'b01,
    GS_FAIL = 2'b10
  } gate_state_t;

  // dna_check needs about 60 cycles to settle, so shorter timeouts would fail good parts.
  localparam int TIMEOUT_MIN = 64;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream register slice used while the gate is in PASS.
// Ready is combinational from downstream ready so a full slice still
// sustains one beat per cycle when the consumer keeps up.
module axis_reg_slice #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_s_tdata,
  input  logic [KEEP_W-1:0] i_s_tkeep,
  input  logic              i_s_tlast,
  input  logic              i_s_tvalid,
  output logic              o_s_tready,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic [KEEP_W-1:0] o_m_tkeep,
  output logic              o_m_tlast,
  output logic              o_m_tvalid,
  input  logic              i_m_tready
);

  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;
  logic              r_valid;
  logic              w_push;

  assign o_s_tready = ~r_valid | i_m_tready;
  assign w_push     = i_en & i_s_tvalid & o_s_tready;

  // Occupancy: push wins over pop so a simultaneous pop/push keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (!i_en) begin
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_valid <= 1'b1;
    end else if (i_m_tready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only moves on a push, so it is held stable while stalled.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data <= i_s_tdata;
      r_keep <= i_s_tkeep;
      r_last <= i_s_tlast;
    end
  end

  assign o_m_tdata  = r_data;
  assign o_m_tkeep  = r_keep;
  assign o_m_tlast  = r_last;
  assign o_m_tvalid = r_valid;

endmodule

// File: rtl/dna_stream_gate.sv
// Gates the PCIe RX TLP stream on the DNA verdict: holds traffic off while
// waiting, forwards it through a register slice on PASS, sinks it on FAIL.
//
// state   | meaning
// --------+-------------------------------------------------------------
// GS_WAIT | verdict unknown; upstream backpressured, timer counting
// GS_PASS | match seen; stream forwarded through the register slice
// GS_FAIL | timeout without match; beats accepted and discarded
//
// PASS and FAIL are sticky until rst_n.
module dna_stream_gate
  import dna_gate_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DATA_W         = 64,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dna_match,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  dropped_pkts
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES < TIMEOUT_MIN) begin : g_bad_timeout
    $error("dna_stream_gate: TIMEOUT_CYCLES (%0d) must be >= %0d", TIMEOUT_CYCLES, TIMEOUT_MIN);
  end

  gate_state_t      r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_dropped;
  logic             w_timeout;
  logic             w_drop_eop;
  logic             w_pass;
  logic             w_slice_ready;

  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_pass     = (r_state == GS_PASS);
  assign w_drop_eop = (r_state == GS_FAIL) & s_axis_tvalid & s_axis_tlast;

  // Verdict FSM and WAIT timer; a match in the timeout cycle still wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= GS_WAIT;
      r_timer <= '0;
    end else if (r_state == GS_WAIT) begin
      r_timer <= r_timer + TMR_W'(1);
      if (dna_match) begin
        r_state <= GS_PASS;
      end else if (w_timeout) begin
        r_state <= GS_FAIL;
      end
    end
  end

  // Count discarded packets by their last beat; saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dropped <= '0;
    end else if (w_drop_eop && (r_dropped != {CNT_W{1'b1}})) begin
      r_dropped <= r_dropped + CNT_W'(1);
    end
  end

  // Upstream ready: stalled in WAIT, slice-driven in PASS, always open in FAIL.
  always_comb begin
    s_axis_tready = 1'b0;
    case (r_state)
      GS_PASS: s_axis_tready = w_slice_ready;
      GS_FAIL: s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // The slice is disabled outside PASS, which keeps m_axis_tvalid low there.
  axis_reg_slice #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W)
  ) u_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_pass),
    .i_s_tdata  (s_axis_tdata),
    .i_s_tkeep  (s_axis_tkeep),
    .i_s_tlast  (s_axis_tlast),
    .i_s_tvalid (s_axis_tvalid),
    .o_s_tready (w_slice_ready),
    .o_m_tdata  (m_axis_tdata),
    .o_m_tkeep  (m_axis_tkeep),
    .o_m_tlast  (m_axis_tlast),
    .o_m_tvalid (m_axis_tvalid),
    .i_m_tready (m_axis_tready)
  );

  assign status       = r_state;
  assign dropped_pkts = r_dropped;

endmodule

// File: tb/tb_dna_stream_gate.sv
// Directed bench for dna_stream_gate: reset, match-to-PASS streaming, random
// downstream stalls, mid-packet reset, timeout-to-FAIL discard, and counter
// saturation on a narrow-counter instance.
module tb_dna_stream_gate;

  logic        clk = 1'b0;
  logic        rst_n, rst4_n, dna_match, match4;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tvalid, m_tready;

  logic        s_tready, m_tlast, m_tvalid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [1:0]  status;
  logic [15:0] dropped;

  logic        s_tready4, m_tlast4, m_tvalid4;
  logic [63:0] m_tdata4;
  logic [7:0]  m_tkeep4;
  logic [1:0]  status4;
  logic [3:0]  dropped4;

  int n_assert = 0;
  int n_fail   = 0;
  int seq      = 0;
  logic [72:0] q[$];

  always #5 clk = ~clk;

  dna_stream_gate u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dna_match     (dna_match),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .status        (status),
    .dropped_pkts  (dropped)
  );

  dna_stream_gate #(
    .TIMEOUT_CYCLES (64),
    .CNT_W          (4)
  ) u_dut4 (
    .clk           (clk),
    .rst_n         (rst4_n),
    .dna_match     (match4),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready4),
    .m_axis_tdata  (m_tdata4),
    .m_axis_tkeep  (m_tkeep4),
    .m_axis_tlast  (m_tlast4),
    .m_axis_tvalid (m_tvalid4),
    .m_axis_tready (m_tready),
    .status        (status4),
    .dropped_pkts  (dropped4)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat i of a stream of plen-beat packets: {tlast, tkeep, tdata}.
  function automatic logic [72:0] beat(input int i, input int plen);
    logic [31:0] iv;
    logic        last;
    logic [7:0]  keep;
    iv   = i;
    last = ((i % plen) == plen - 1);
    keep = last ? 8'h0F : 8'hFF;
    return {last, keep, 16'hBEEF, iv[15:0], ~iv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream nbeats through the PASS slice against a queue model of its contents.
  task automatic stream(input int nbeats, input int plen, input bit rnd);
    int  start;
    int  cyc;
    bit  ev, pop, push;
    start = seq;
    cyc   = 0;
    while (((seq < start + nbeats) || (q.size() != 0)) && (cyc < 1000)) begin
      if (seq < start + nbeats) begin
        {s_tlast, s_tkeep, s_tdata} = beat(seq, plen);
        s_tvalid = 1'b1;
      end else begin
        s_tvalid = 1'b0;
      end
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ev = (q.size() != 0);
      check("m_valid", m_tvalid, ev);
      if (ev) check("m_beat", {m_tlast, m_tkeep, m_tdata}, q[0]);
      check("s_ready", s_tready, (!ev || m_tready));
      pop  = ev && m_tready;
      push = s_tvalid && (!ev || m_tready);
      tick();
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(beat(seq, plen));
        seq++;
      end
      cyc++;
    end
    s_tvalid = 1'b0;
    check("stream_done", q.size() + (start + nbeats - seq), 0);
    if (!rnd) check("throughput_cycles", cyc, nbeats + 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    rst4_n    = 1'b0;
    dna_match = 1'b0;
    match4    = 1'b0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tlast   = 1'b0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_status", status, 2'b00);
    check("rst_m_valid", m_tvalid, 1'b0);
    check("rst_s_ready", s_tready, 1'b0);
    check("rst_dropped", dropped, 16'd0);

    // Match at cycle 60, upstream already presenting the first beat
    rst_n = 1'b1;
    repeat (60) tick();
    {s_tlast, s_tkeep, s_tdata} = beat(0, 3);
    s_tvalid  = 1'b1;
    dna_match = 1'b1;
    #1;
    check("wait_status", status, 2'b00);
    check("wait_s_ready", s_tready, 1'b0);
    check("wait_m_valid", m_tvalid, 1'b0);
    tick();
    dna_match = 1'b0;
    check("pass_status", status, 2'b01);

    // Full-rate streaming, then random downstream stalls
    stream(30, 3, 1'b0);
    stream(60, 3, 1'b1);

    // Reset mid-packet while a beat sits in the slice
    {s_tlast, s_tkeep, s_tdata} = beat(seq, 3);
    s_tvalid = 1'b1;
    m_tready = 1'b0;
    tick();
    check("pre_rst_m_valid", m_tvalid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_status", status, 2'b00);
    check("mid_rst_m_valid", m_tvalid, 1'b0);
    check("mid_rst_s_ready", s_tready, 1'b0);
    repeat (255) tick();
    check("timer_restart_status", status, 2'b00);
    // Timer is at its limit here, so this match coincides with the timeout
    dna_match = 1'b1;
    tick();
    check("match_wins_status", status, 2'b01);
    dna_match = 1'b0;
    repeat (3) tick();
    check("pass_sticky_status", status, 2'b01);
    s_tvalid = 1'b0;
    m_tready = 1'b1;

    // Timeout to FAIL with no match
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (255) tick();
    check("pre_timeout_status", status, 2'b00);
    tick();
    check("timeout_status", status, 2'b10);
    check("timeout_dropped", dropped, 16'd0);
    for (int p = 0; p < 10; p++) begin
      {s_tlast, s_tkeep, s_tdata} = beat(p, 2);
      s_tvalid = 1'b1;
      #1;
      check("fail_s_ready", s_tready, 1'b1);
      check("fail_m_valid", m_tvalid, 1'b0);
      tick();
    end
    s_tvalid = 1'b0;
    #1;
    check("fail_dropped", dropped, 16'd5);
    dna_match = 1'b1;
    tick();
    dna_match = 1'b0;
    tick();
    check("fail_sticky_status", status, 2'b10);

    // Saturation on the 4-bit counter instance
    rst4_n = 1'b1;
    repeat (64) tick();
    check("sat_status", status4, 2'b10);
    for (int i = 0; i < 23; i++) begin
      {s_tlast, s_tkeep, s_tdata} = beat(i, 1);
      s_tvalid = 1'b1;
      tick();
      check("sat_dropped", dropped4, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    s_tvalid = 1'b0;
    tick();
    check("sat_hold", dropped4, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
